// File: rtl/neuron_seq.sv
// neuron_seq: timestep sequencer streaming active-input weights into one integrate-and-fire neuron
// Ports: CLK/nRST clock and async active-low reset; start/spikes_in begin a timestep;
//   busy/done/spike report progress and result; w_addr/w_data access the synchronous weight
//   memory (1-cycle latency); ne_data_in/ne_clken/ne_clr/ne_spike_out drive the neuron.
// Optional: define NEURON_SEQ_REFRACT_EN to skip REFRACT_STEPS timesteps after each fire.
module neuron_seq #(
  parameter int N_INPUTS      = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int REFRACT_STEPS = 2,
  localparam int AW = $clog2(N_INPUTS)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    start,
  input  logic [N_INPUTS-1:0]     spikes_in,
  output logic                    busy,
  output logic                    done,
  output logic                    spike,
  output logic [AW-1:0]           w_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [WEIGHT_WIDTH-1:0] ne_data_in,
  output logic                    ne_clken,
  output logic                    ne_clr,
  input  logic                    ne_spike_out
);
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EVAL, REPORT} state_e;
  state_e              state_q;
  logic [N_INPUTS-1:0] mask_q;
  logic [AW-1:0]       idx_q;
  logic                rd_vld_q;
  logic                fire_q;
`ifdef NEURON_SEQ_REFRACT_EN
  logic [7:0]          refr_q;
`endif
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
      fire_q   <= 1'b0;
`ifdef NEURON_SEQ_REFRACT_EN
      refr_q   <= '0;
`endif
    end else begin
      // rd_vld tracks the address issued last cycle, aligning with w_data; it is 0 in the first SCAN cycle
      rd_vld_q <= (state_q == SCAN) && mask_q[idx_q];
      case (state_q)
        IDLE: if (start) begin
          mask_q <= spikes_in;
          idx_q  <= '0;
`ifdef NEURON_SEQ_REFRACT_EN
          if (refr_q != 8'd0) begin
            refr_q  <= refr_q - 8'd1;
            fire_q  <= 1'b0;
            state_q <= REPORT;
          end else state_q <= SCAN;
`else
          state_q <= SCAN;
`endif
        end
        SCAN: if (idx_q == AW'(N_INPUTS - 1)) state_q <= DRAIN;
              else idx_q <= idx_q + AW'(1);
        DRAIN: state_q <= EVAL;
        EVAL: begin
          fire_q  <= ne_spike_out;
          state_q <= REPORT;
        end
        REPORT: begin
`ifdef NEURON_SEQ_REFRACT_EN
          if (fire_q) refr_q <= 8'(REFRACT_STEPS);
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy       = state_q != IDLE;
  assign done       = state_q == REPORT;
  assign spike      = done && fire_q;
  assign ne_clr     = spike;
  assign w_addr     = (state_q == SCAN) ? idx_q : '0;
  assign ne_clken   = rd_vld_q;
  assign ne_data_in = rd_vld_q ? w_data : '0;
endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: randomized scoreboard bench for neuron_seq with weight memory and neuron models
module tb_neuron_seq;
  localparam int N = 16, WW = 8, RS = 2, TH = 10, AW = $clog2(N);
`ifdef NEURON_SEQ_REFRACT_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif
  logic CLK = 1'b0, nRST = 1'b0, start = 1'b0;
  logic [N-1:0] spikes_in = '0;
  logic busy, done, spike, ne_clken, ne_clr, ne_spike_out;
  logic [AW-1:0] w_addr;
  logic [WW-1:0] w_data, ne_data_in;
  logic [WW-1:0] w [N];
  logic [15:0] acc_n;
  neuron_seq #(.N_INPUTS(N), .WEIGHT_WIDTH(WW), .REFRACT_STEPS(RS)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .spikes_in(spikes_in), .busy(busy), .done(done),
    .spike(spike), .w_addr(w_addr), .w_data(w_data), .ne_data_in(ne_data_in),
    .ne_clken(ne_clken), .ne_clr(ne_clr), .ne_spike_out(ne_spike_out));
  always #5 CLK = ~CLK;
  always @(posedge CLK) w_data <= w[w_addr];
  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      acc_n <= '0;
      ne_spike_out <= 1'b0;
    end else if (ne_clr) begin
      acc_n <= '0;
      ne_spike_out <= 1'b0;
    end else if (ne_clken) begin
      acc_n <= acc_n + 16'(ne_data_in);
      ne_spike_out <= (acc_n + 16'(ne_data_in)) >= 16'(TH);
    end
  typedef struct {int c0; logic [N-1:0] m; bit skip; bit spk;} exp_t;
  exp_t q[$];
  int cyc = 0, vecs = 0, errs = 0, acc_m = 0, refr_m = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask
  int cnt, rel, lat, k;
  bit act;
  always @(negedge CLK) begin
    #1;
    if (!nRST) cnt = 0;
    else begin
      act = q.size() > 0;
      rel = act ? cyc - q[0].c0 : -1;
      lat = (act && q[0].skip) ? 1 : N + 3;
      chk("busy", 32'(busy), 32'(act && rel >= 1 && rel <= lat));
      chk("w_addr", 32'(w_addr), (act && !q[0].skip && rel >= 1 && rel <= N) ? rel - 1 : 0);
      if (ne_clken) begin
        cnt++;
        k = rel - 2;
        if (act && !q[0].skip && k >= 0 && k < N && q[0].m[k]) chk("clken_data", 32'(ne_data_in), 32'(w[k]));
        else chk("clken_slot", 32'(rel), 32'hFFFF_FFFF);
      end else chk("data_idle", 32'(ne_data_in), 0);
      if (done) begin
        if (!act) chk("unexpected_done", 1, 0);
        else begin
          chk("done_cycle", rel, lat);
          chk("spike", 32'(spike), 32'(q[0].spk));
          chk("ne_clr", 32'(ne_clr), 32'(q[0].spk));
          chk("clken_count", cnt, q[0].skip ? 0 : $countones(q[0].m));
          void'(q.pop_front());
        end
        cnt = 0;
      end else chk("spike_idle", {30'd0, spike, ne_clr}, 0);
    end
  end
  task automatic push(input logic [N-1:0] m, output int l);
    exp_t e;
    e.c0 = cyc;
    e.m = m;
    e.skip = refr_m > 0;
    if (e.skip) begin
      refr_m--;
      e.spk = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) if (m[i]) acc_m += int'(w[i]);
      e.spk = acc_m >= TH;
      if (e.spk) begin
        acc_m = 0;
        if (REFR) refr_m = RS;
      end
    end
    l = e.skip ? 1 : N + 3;
    q.push_back(e);
  endtask
  task automatic step(input logic [N-1:0] m, input bit pulses);
    int l;
    start = 1'b1;
    spikes_in = m;
    push(m, l);
    @(negedge CLK);
    start = 1'b0;
    spikes_in = N'($urandom);
    for (int i = 1; i <= l; i++) begin
      start = pulses && (i == 5 || i == 10);
      @(negedge CLK);
    end
    start = 1'b0;
  endtask
  task automatic reset_mid(input logic [N-1:0] m);
    int l;
    start = 1'b1;
    spikes_in = m;
    push(m, l);
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    nRST = 1'b0;
    q.delete();
    acc_m = 0;
    refr_m = 0;
    #1 chk("rst_outputs", {busy, done, spike, ne_clken, ne_clr, w_addr, ne_data_in}, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask
  initial begin
    for (int i = 0; i < N; i++) w[i] = WW'(i + 1);
    @(negedge CLK);
    #1 chk("reset_outputs", {busy, done, spike, ne_clken, ne_clr, w_addr, ne_data_in}, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    step(16'h0005, 1'b0);
    step(16'h0000, 1'b0);
    step(16'hFFFF, 1'b0);
    step(16'h0003, 1'b0);
    step(16'h0001, 1'b0);
    step(16'h0002, 1'b0);
    step(16'h00F0, 1'b1);
    reset_mid(16'hFFFF);
    step(16'h0005, 1'b0);
    repeat (40) begin
      for (int i = 0; i < N; i++) w[i] = WW'($urandom_range(0, 4));
      step(N'($urandom & $urandom), $urandom_range(0, 3) == 0);
    end
    repeat (3) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
